vc_iter_divider: RTL

Multi-cycle restoring integer divider. It sequences one W+1-bit subtract/compare datapath (subtractor, less-than comparator, sign/zero extension) over W iterations to produce quotient and remainder. It sits beside the single-cycle arithmetic components as the shared long-latency divide unit for the processor datapath. A val/rdy handshake is used on both the request and response sides.

---
 rtl/vc_iter_divider.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vc_iter_divider.sv
// rtl/vc_iter_divider.sv - multi-cycle restoring divider, one quotient bit per cycle
// Operands are reduced to magnitudes at accept; signs are reapplied when the result is registered.
module vc_iter_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [W-1:0] in_dividend,
  input  logic [W-1:0] in_divisor,
  input  logic         in_signed,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out_quot,
  output logic [W-1:0] out_rem,
  output logic         out_divzero
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  p;
  logic [W-1:0]  q;
  logic [W-1:0]  dmag;
  logic [W-1:0]  dividend_r;
  logic          qneg;
  logic          rneg;
  logic          dz;
  logic          fin;
  logic [CW-1:0] cnt;

  logic          dd_neg;
  logic          dv_neg;
  logic [W-1:0]  dd_mag;
  logic [W-1:0]  dv_mag;
  logic [W:0]    t;
  logic          ge;
  logic [W-1:0]  diff;
  logic [W-1:0]  quot_fin;
  logic [W-1:0]  rem_fin;

  always_comb begin
    dd_neg   = in_signed & in_dividend[W-1];
    dv_neg   = in_signed & in_divisor[W-1];
    dd_mag   = dd_neg ? (~in_dividend + 1'b1) : in_dividend;
    dv_mag   = dv_neg ? (~in_divisor + 1'b1) : in_divisor;
    t        = {p, q[W-1]};
    ge       = (t >= {1'b0, dmag});
    // The true difference always fits in W bits, so the low W bits suffice.
    diff     = t[W-1:0] - dmag;
    quot_fin = qneg ? (~q + 1'b1) : q;
    rem_fin  = rneg ? (~p + 1'b1) : p;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_rdy      <= 1'b1;
      out_val     <= 1'b0;
      out_quot    <= '0;
      out_rem     <= '0;
      out_divzero <= 1'b0;
      p           <= '0;
      q           <= '0;
      dmag        <= '0;
      dividend_r  <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      dz          <= 1'b0;
      fin         <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            p          <= '0;
            q          <= dd_mag;
            dmag       <= dv_mag;
            dividend_r <= in_dividend;
            qneg       <= dd_neg ^ dv_neg;
            rneg       <= dd_neg;
            dz         <= (in_divisor == '0);
            fin        <= 1'b0;
            cnt        <= '0;
            in_rdy     <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          // After the W-th iteration one more cycle registers the signed/divzero result.
          if (fin) begin
            out_quot    <= dz ? '1 : quot_fin;
            out_rem     <= dz ? dividend_r : rem_fin;
            out_divzero <= dz;
            out_val     <= 1'b1;
            state       <= DONE;
          end else begin
            p   <= ge ? diff : t[W-1:0];
            q   <= {q[W-2:0], ge};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) fin <= 1'b1;
          end
        end
        DONE: begin
          if (out_rdy) begin
            out_val <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          out_val <= 1'b0;
          in_rdy  <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
